// File: rtl/cs_pkg.sv
// Shared constants, state encoding and helpers for the CS sliding-window sequencer.
package cs_pkg;

  localparam int DW        = 8;   // sample width
  localparam int YW        = 10;  // result width
  localparam int WIN       = 9;   // window length
  localparam int FILL_W    = 4;   // fill counter width (WIN <= 15)
  localparam int IN_DEPTH  = 4;   // input sample FIFO depth
  localparam int OUT_DEPTH = 2;   // output result FIFO depth
  localparam int DP_LAT    = 1;   // dp_shift to dp_y latency

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Window occupancy after one more shift; it saturates once the window is full.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f >= FILL_W'(WIN)) ? FILL_W'(WIN) : f + FILL_W'(1);
  endfunction

endpackage

// File: rtl/cs_stream_ctrl_fifo.sv
// Small synchronous FIFO with clear. A pop and a push may happen in the same
// cycle, including when full: the pop frees the slot the push then uses.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];

  // Storage, pointers and occupancy; clear empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cs_stream_ctrl.sv
// Sequencer for the 9-sample sliding-window CS datapath. Buffers upstream
// samples, issues one dp_shift per sample, tracks window fill, and captures
// full-window results DP_LAT cycles after their shift into an output FIFO.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never depends on ready, and out_data is held stable while
// out_valid is 1 and out_ready is 0.
module cs_stream_ctrl
  import cs_pkg::*;
#(
  parameter int DW        = cs_pkg::DW,
  parameter int YW        = cs_pkg::YW,
  parameter int WIN       = cs_pkg::WIN,
  parameter int IN_DEPTH  = cs_pkg::IN_DEPTH,
  parameter int OUT_DEPTH = cs_pkg::OUT_DEPTH,
  parameter int DP_LAT    = cs_pkg::DP_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              dp_shift,
  output logic [DW-1:0]     dp_x,
  output logic              dp_clr,
  input  logic [YW-1:0]     dp_y,
  output logic              out_valid,
  output logic [YW-1:0]     out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [FILL_W-1:0] fill_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CW  = $clog2(OUT_DEPTH) + 2;
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DP_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]     inflight_q, inflight_d;

  logic              active;
  logic              flush_take;
  logic              in_push;
  logic              in_full;
  logic              in_empty;
  logic [ICW-1:0]    in_cnt;
  logic [DW-1:0]     in_head;
  logic              out_full;
  logic              out_empty;
  logic [OCW-1:0]    out_cnt;
  logic              out_pop;
  logic              shift_tag;
  logic              tag_in;
  logic              tag_out;
  logic [CW-1:0]     slots_used;
  logic [CW-1:0]     slots_avail;
  logic              credit_ok;
  logic              unused_fifo_bits;

  assign active     = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign flush_take = active & flush;

  // Flush wins over a same-cycle sample: the sample is simply not accepted.
  assign in_ready = active & ~in_full & ~flush;
  assign in_push  = in_valid & in_ready;

  // The shift leaves the window full, so it produces a result that needs a slot.
  assign shift_tag = (fill_q >= FILL_W'(WIN - 1));

  // A slot is free if results held plus results in flight are below the depth.
  // A pop in this cycle frees a slot early enough for a result that lands
  // DP_LAT cycles later, which is what keeps RUN bubble-free with a live sink.
  assign out_pop     = out_valid & out_ready;
  assign slots_used  = CW'(out_cnt) + inflight_q;
  assign slots_avail = CW'(OUT_DEPTH) + CW'(out_pop);
  assign credit_ok   = (slots_used < slots_avail);

  assign dp_shift = active & ~flush & ~in_empty & (~shift_tag | credit_ok);
  assign dp_x     = dp_shift ? in_head : '0;
  assign tag_in   = dp_shift & shift_tag;
  assign tag_out  = tag_q[DP_LAT-1];

  // dp_clr is held low while reset is asserted so every output except busy is 0 then.
  assign dp_clr = (state_q == ST_INIT) & reset;

  assign out_valid = ~out_empty;
  assign busy      = (state_q != ST_FILL) | ~in_empty | ~out_empty | (inflight_q != '0);
  assign fill_cnt  = fill_q;
  assign dbg_state = state_q;

  assign unused_fifo_bits = ^{in_cnt, out_full};

  sync_fifo #(.W(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_take),
    .push  (in_push),
    .wdata (in_data),
    .pop   (dp_shift),
    .full  (in_full),
    .empty (in_empty),
    .count (in_cnt),
    .head  (in_head)
  );

  sync_fifo #(.W(YW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (tag_out),
    .wdata (dp_y),
    .pop   (out_pop),
    .full  (out_full),
    .empty (out_empty),
    .count (out_cnt),
    .head  (out_data)
  );

  // Tag delay line (marks which dp_y to capture) and the count of tags still inside it.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = tag_in;
    for (int i = 1; i < DP_LAT; i++) tag_d[i] = tag_q[i-1];
    inflight_d = inflight_q + CW'(tag_in) - CW'(tag_out);
  end

  // Sequencer next state and window fill tracking.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_FILL;
        fill_d  = '0;
      end
      ST_FILL, ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (dp_shift) begin
          fill_d = fill_inc(fill_q);
          if (fill_inc(fill_q) == FILL_W'(WIN)) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Results already shifted are kept; restart only once they have all landed.
        if (inflight_q == '0) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, fill, tag line and in-flight count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      fill_q     <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Bench for cs_stream_ctrl with a behavioural datapath (running sum of the
// last 9 shifted samples, one cycle latency) and a sample/result scoreboard.
`timescale 1ns/1ps
module tb_cs_stream_ctrl;
  import cs_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              dp_shift;
  logic [DW-1:0]     dp_x;
  logic              dp_clr;
  logic [YW-1:0]     dp_y;
  logic              out_valid;
  logic [YW-1:0]     out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [FILL_W-1:0] fill_cnt;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  cs_stream_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .dp_shift  (dp_shift),
    .dp_x      (dp_x),
    .dp_clr    (dp_clr),
    .dp_y      (dp_y),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .fill_cnt  (fill_cnt),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [DW-1:0] dp_win [WIN];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) dp_win[i] <= '0;
    end else if (dp_clr) begin
      for (int i = 0; i < WIN; i++) dp_win[i] <= '0;
    end else if (dp_shift) begin
      dp_win[0] <= dp_x;
      for (int i = 1; i < WIN; i++) dp_win[i] <= dp_win[i-1];
    end
  end

  always_comb begin
    dp_y = '0;
    for (int i = 0; i < WIN; i++) dp_y = dp_y + YW'(dp_win[i]);
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] in_q  [$];
  logic [DW-1:0] win_q [$];
  logic [YW-1:0] exp_q [$];
  int            m_sh = 0;
  int            n_shift = 0;
  int            n_clr = 0;
  int            n_pop = 0;
  logic [YW-1:0] last_pop = '0;
  logic          hold_v = 1'b0;
  logic [YW-1:0] hold_d = '0;

  function automatic logic [YW-1:0] win_sum();
    logic [YW-1:0] s = '0;
    foreach (win_q[i]) s = s + YW'(win_q[i]);
    return s;
  endfunction

  always @(negedge clk) begin
    logic [DW-1:0] ex;
    logic [YW-1:0] er;
    if (!reset) begin
      in_q.delete();
      win_q.delete();
      exp_q.delete();
      m_sh   = 0;
      hold_v = 1'b0;
    end else begin
      chk("fill_cnt", 32'(fill_cnt), (m_sh > WIN) ? WIN : m_sh);
      if (hold_v) begin
        chk("out_hold_valid", 32'(out_valid), 1);
        chk("out_hold_data", 32'(out_data), 32'(hold_d));
      end
      if (dp_shift) begin
        n_shift++;
        chk("shift_has_sample", 32'(in_q.size() != 0), 1);
        if (in_q.size() != 0) begin
          ex = in_q.pop_front();
          chk("dp_x", 32'(dp_x), 32'(ex));
          win_q.push_back(ex);
          if (win_q.size() > WIN) void'(win_q.pop_front());
          m_sh++;
          if (m_sh >= WIN) exp_q.push_back(win_sum());
        end
      end
      if (in_valid && in_ready) in_q.push_back(in_data);
      if (flush) in_q.delete();
      if (dp_clr) begin
        n_clr++;
        win_q.delete();
        m_sh = 0;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        last_pop = out_data;
        chk("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          er = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(er));
        end
      end
      hold_v = out_valid & ~out_ready;
      hold_d = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic ok = 1'b0;
    logic r;
    in_valid = 1'b1;
    in_data  = d;
    for (int b = 0; b < 50 && !ok; b++) begin
      #3;
      r = in_ready;
      tick();
      ok = r;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 1);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_rdy;
    logic          e_shift;
    logic [DW-1:0] e_x;
    logic          e_clr;
    logic          e_ov;
    logic [YW-1:0] e_od;
    logic [3:0]    e_fill;
    logic          e_busy;
  } vec_t;

  vec_t tbl [16];

  // Cycle 0 is the INIT cycle right after reset release; X=k is offered in cycle k.
  task automatic build_table();
    for (int k = 0; k < 16; k++) begin
      tbl[k].iv      = (k >= 1 && k <= 11);
      tbl[k].id      = tbl[k].iv ? DW'(k) : '0;
      tbl[k].ordy    = 1'b1;
      tbl[k].e_rdy   = (k >= 1);
      tbl[k].e_shift = (k >= 2 && k <= 12);
      tbl[k].e_x     = tbl[k].e_shift ? DW'(k - 1) : '0;
      tbl[k].e_clr   = (k == 0);
      tbl[k].e_fill  = (k <= 2) ? 4'd0 : ((k - 2 > WIN) ? 4'(WIN) : 4'(k - 2));
      tbl[k].e_busy  = (k != 1);
      tbl[k].e_ov    = 1'b0;
      tbl[k].e_od    = '0;
    end
    tbl[12].e_ov = 1'b1; tbl[12].e_od = 10'd45;
    tbl[13].e_ov = 1'b1; tbl[13].e_od = 10'd54;
    tbl[14].e_ov = 1'b1; tbl[14].e_od = 10'd63;
  endtask

  task automatic run_table();
    for (int k = 0; k < 16; k++) begin
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].id;
      out_ready = tbl[k].ordy;
      #3;
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[k].e_rdy));
      chk("tbl_dp_shift", 32'(dp_shift), 32'(tbl[k].e_shift));
      if (tbl[k].e_shift) chk("tbl_dp_x", 32'(dp_x), 32'(tbl[k].e_x));
      chk("tbl_dp_clr", 32'(dp_clr), 32'(tbl[k].e_clr));
      chk("tbl_fill_cnt", 32'(fill_cnt), 32'(tbl[k].e_fill));
      chk("tbl_busy", 32'(busy), 32'(tbl[k].e_busy));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk("tbl_out_data", 32'(out_data), 32'(tbl[k].e_od));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_dp_shift"}, 32'(dp_shift), 0);
    chk({tag, "_dp_clr"}, 32'(dp_clr), 0);
    chk({tag, "_fill_cnt"}, 32'(fill_cnt), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_out_data"}, 32'(out_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int b_shift, b_clr, b_pop, acc_n;
    logic r;

    build_table();

    // Reset state, then X=1..11 through the table.
    repeat (3) tick();
    #1;
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;
    run_table();

    // Back-pressure: sink stalled, 10 samples offered.
    out_ready = 1'b0;
    b_shift = n_shift;
    b_pop = n_pop;
    acc_n = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(100 + acc_n);
      #3;
      r = in_ready;
      tick();
      if (r) acc_n++;
    end
    in_valid = 1'b0;
    #3;
    chk("bp_shifts", 32'(n_shift - b_shift), 2);
    chk("bp_accepted", 32'(acc_n), 6);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    tick();
    out_ready = 1'b1;
    for (int i = acc_n; i < 10; i++) send(DW'(100 + i));
    repeat (15) tick();
    chk("bp_results", 32'(n_pop - b_pop), 10);
    chk("bp_exp_empty", 32'(exp_q.size()), 0);

    // Flush with 3 samples queued and 1 result in flight.
    out_ready = 1'b0;
    for (int s = 1; s <= 6; s++) send(DW'(20 + s));
    b_pop = n_pop;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    b_shift = n_shift;
    b_clr = n_clr;
    #3;
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_no_shift", 32'(dp_shift), 0);
    tick();
    flush = 1'b0;
    repeat (5) tick();
    #3;
    chk("flush_shifts", 32'(n_shift - b_shift), 0);
    chk("flush_clr_pulses", 32'(n_clr - b_clr), 1);
    chk("flush_fill_cnt", 32'(fill_cnt), 0);
    chk("flush_in_ready_after", 32'(in_ready), 1);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    chk("flush_results", 32'(n_pop - b_pop), 3);
    chk("flush_exp_empty", 32'(exp_q.size()), 0);
    b_pop = n_pop;
    for (int s = 0; s < 9; s++) send(DW'(2));
    repeat (6) tick();
    chk("after_flush_count", 32'(n_pop - b_pop), 1);
    chk("after_flush_sum", 32'(last_pop), 18);

    // Flush and in_valid in the same cycle.
    in_valid = 1'b1;
    in_data  = DW'(8'h55);
    flush    = 1'b1;
    #3;
    chk("flush_vs_valid_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    b_shift  = n_shift;
    repeat (5) tick();
    #3;
    chk("flush_vs_valid_shifts", 32'(n_shift - b_shift), 0);
    chk("flush_vs_valid_fill", 32'(fill_cnt), 0);
    chk("idle_fill_busy", 32'(busy), 0);
    tick();

    // Randomized traffic against the scoreboard.
    b_pop = n_pop;
    for (int c = 0; c < 700; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom_range(0, 113));
      out_ready = ((c / 100) % 2 == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("rand_exp_empty", 32'(exp_q.size()), 0);
    chk("rand_in_empty", 32'(in_q.size()), 0);
    chk("rand_results_seen", 32'((n_pop - b_pop) > 100), 1);

    // Reset mid-RUN with results buffered.
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(7);
      tick();
    end
    #3;
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    chk("pre_reset_fill", 32'(fill_cnt), WIN);
    @(posedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
